// File: rtl/hdmi_tx_vpg_pkg.sv
// Shared definitions for the HDMI TX video pattern generator sequencer:
// register map, field positions, FSM encoding and reset defaults.
package hdmi_tx_vpg_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned DWELL_W    = 16;
    localparam int unsigned FRAME_W    = 16;
    localparam int unsigned MASK_W     = 4;
    localparam int unsigned COLOR_W    = 2;
    localparam int unsigned NUM_COLORS = 4;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_DWELL  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 2'd3;

    localparam int unsigned CTRL_AUTO_BIT = 0;
    localparam int unsigned CTRL_MAN_LO   = 2;
    localparam int unsigned CTRL_MAN_HI   = 3;

    localparam logic [DWELL_W-1:0] DWELL_RST_DEFAULT = 16'd60;
    localparam logic [MASK_W-1:0]  MASK_RST_DEFAULT  = 4'hF;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // First enabled color above cur (wrapping); holds cur when none other is enabled.
    function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] cur,
                                                      input logic [MASK_W-1:0]  mask);
        logic [COLOR_W-1:0] cand;
        logic               found;
        next_color = cur;
        found      = 1'b0;
        for (int i = 1; i < NUM_COLORS; i++) begin
            cand = cur + COLOR_W'(i);
            if (!found && mask[cand]) begin
                next_color = cand;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/hdmi_tx_vpg_sequencer_if.sv
// Avalon-MM register port of the VPG sequencer.
interface hdmi_tx_vpg_sequencer_if;
    import hdmi_tx_vpg_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hdmi_tx_vsync_edge.sv
// Registers vsync once and flags the first cycle it is seen high (frame_tick).
module hdmi_tx_vsync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frame_tick = vsync & ~vsync_q;

endmodule

// File: rtl/hdmi_tx_vpg_sequencer.sv
// Frame-synchronous color pattern sequencer for the HDMI TX VPG: manual color
// select in IDLE, automatic masked rotation with a per-color frame dwell in RUN.
module hdmi_tx_vpg_sequencer
    import hdmi_tx_vpg_pkg::*;
#(
    parameter logic [DWELL_W-1:0] DWELL_RST = DWELL_RST_DEFAULT,
    parameter logic [MASK_W-1:0]  MASK_RST  = MASK_RST_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hdmi_tx_vpg_sequencer_if.slave avmm,
    input  logic                   vsync,
    output logic [COLOR_W-1:0]     color_sel,
    output logic                   color_chg
);

    logic                 frame_tick;
    logic                 wr_en;
    logic                 ctrl_auto;
    logic [COLOR_W-1:0]   man_color;
    logic [DWELL_W-1:0]   dwell_reg;
    logic [MASK_W-1:0]    mask_reg;
    state_t               state, state_nxt;
    logic [DWELL_W-1:0]   dwell_cnt, dwell_nxt, dwell_lim;
    logic [FRAME_W-1:0]   frame_cnt, frame_nxt;
    logic [COLOR_W-1:0]   color_nxt;
    logic                 running;
    logic                 unused_wd;

    hdmi_tx_vsync_edge u_vsync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign wr_en     = avmm.chipselect & ~avmm.write_n;
    assign running   = (state == ST_RUN);
    assign dwell_lim = (dwell_reg == '0) ? '0 : dwell_reg - DWELL_W'(1);
    assign unused_wd = ^avmm.writedata[DATA_W-1:DWELL_W];

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_auto <= 1'b0;
            man_color <= '0;
            dwell_reg <= DWELL_RST;
            mask_reg  <= MASK_RST;
        end else if (wr_en) begin
            case (avmm.address)
                ADDR_CTRL: begin
                    ctrl_auto <= avmm.writedata[CTRL_AUTO_BIT];
                    man_color <= avmm.writedata[CTRL_MAN_HI:CTRL_MAN_LO];
                end
                ADDR_DWELL: dwell_reg <= avmm.writedata[DWELL_W-1:0];
                ADDR_MASK:  mask_reg  <= avmm.writedata[MASK_W-1:0];
                default:    ;
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            dwell_cnt <= '0;
            frame_cnt <= '0;
            color_sel <= '0;
            color_chg <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            frame_cnt <= frame_nxt;
            color_sel <= color_nxt;
            color_chg <= (color_nxt != color_sel);
        end
    end

    // Next state: the tick sees pre-write registers; write-induced clears override it.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        frame_nxt = frame_cnt;
        color_nxt = color_sel;

        if (frame_tick) begin
            frame_nxt = frame_cnt + FRAME_W'(1);
            case (state)
                ST_IDLE: color_nxt = man_color;
                ST_RUN: begin
                    if (dwell_cnt == dwell_lim) begin
                        dwell_nxt = '0;
                        color_nxt = next_color(color_sel, mask_reg);
                    end else begin
                        dwell_nxt = dwell_cnt + DWELL_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (wr_en) begin
            case (avmm.address)
                ADDR_CTRL: begin
                    state_nxt = avmm.writedata[CTRL_AUTO_BIT] ? ST_RUN : ST_IDLE;
                    if (state == ST_IDLE && avmm.writedata[CTRL_AUTO_BIT]) begin
                        dwell_nxt = '0;
                    end
                end
                ADDR_DWELL, ADDR_MASK: dwell_nxt = '0;
                default: ;
            endcase
        end
    end

    // Zero-wait-state register readback.
    always_comb begin
        avmm.readdata = '0;
        case (avmm.address)
            ADDR_CTRL:   avmm.readdata = DATA_W'({man_color, 1'b0, ctrl_auto});
            ADDR_DWELL:  avmm.readdata = DATA_W'(dwell_reg);
            ADDR_STATUS: avmm.readdata = {frame_cnt, 13'b0, running, color_sel};
            ADDR_MASK:   avmm.readdata = DATA_W'(mask_reg);
            default:     avmm.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_hdmi_tx_vpg_sequencer.sv
// Directed self-checking bench for hdmi_tx_vpg_sequencer.
module tb_hdmi_tx_vpg_sequencer;
    import hdmi_tx_vpg_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vsync;
    logic [1:0] color_sel;
    logic       color_chg;
    int         n_vec = 0;
    int         n_err = 0;

    hdmi_tx_vpg_sequencer_if bus ();

    hdmi_tx_vpg_sequencer #(
        .DWELL_RST (16'd60),
        .MASK_RST  (4'hF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avmm      (bus.slave),
        .vsync     (vsync),
        .color_sel (color_sel),
        .color_chg (color_chg)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        vsync          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    // One-cycle vsync pulse; returns on the falling edge after the tick's rising edge.
    task automatic vsync_pulse();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0, 32'd60, 32'h0, 32'hF};
        apply_reset();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            n_vec++;
            if (rd !== exp_rd[a]) begin
                n_err++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd, exp_rd[a]);
            end
        end
        n_vec++;
        if (color_sel !== 2'd0 || color_chg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got sel=%0d chg=%b expected sel=0 chg=0", color_sel, color_chg);
        end
    endtask

    task automatic test_manual();
        logic [31:0] rd;
        bus_write(ADDR_CTRL, 32'h8);
        n_vec++;
        if (color_sel !== 2'd0) begin
            n_err++;
            $display("FAIL manual_pre_tick: got sel=%0d expected 0", color_sel);
        end
        vsync_pulse();
        n_vec++;
        if (color_sel !== 2'd2 || color_chg !== 1'b1) begin
            n_err++;
            $display("FAIL manual_tick: got sel=%0d chg=%b expected sel=2 chg=1", color_sel, color_chg);
        end
        @(negedge clk);
        n_vec++;
        if (color_sel !== 2'd2 || color_chg !== 1'b0) begin
            n_err++;
            $display("FAIL manual_chg_width: got sel=%0d chg=%b expected sel=2 chg=0", color_sel, color_chg);
        end
        bus_read(ADDR_STATUS, rd);
        n_vec++;
        if (rd !== 32'h0001_0002) begin
            n_err++;
            $display("FAIL manual_status: got %h expected 00010002", rd);
        end
    endtask

    task automatic test_auto_rotate();
        logic [31:0] rd;
        logic [1:0]  exp_c [8];
        logic        exp_g [8];
        exp_c = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        bus_write(ADDR_MASK, 32'hF);
        bus_write(ADDR_DWELL, 32'd2);
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_STATUS, rd);
        n_vec++;
        if (rd !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL auto_running: got %h expected 00000004", rd);
        end
        for (int t = 0; t < 8; t++) begin
            vsync_pulse();
            n_vec++;
            if (color_sel !== exp_c[t] || color_chg !== exp_g[t]) begin
                n_err++;
                $display("FAIL auto_tick%0d: got sel=%0d chg=%b expected sel=%0d chg=%b",
                         t + 1, color_sel, color_chg, exp_c[t], exp_g[t]);
            end
        end
        bus_read(ADDR_STATUS, rd);
        n_vec++;
        if (rd !== 32'h0008_0004) begin
            n_err++;
            $display("FAIL auto_status: got %h expected 00080004", rd);
        end
    endtask

    task automatic test_dwell_zero_mask();
        // Per tick: mask written before it (or none), expected color and chg.
        logic [4:0] mask_wr [11];
        logic [1:0] exp_c   [11];
        logic       exp_g   [11];
        mask_wr = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h10, 5'h00, 5'h00, 5'h11, 5'h00, 5'h18, 5'h12};
        exp_c   = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1};
        exp_g   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        bus_write(ADDR_MASK, 32'h5);
        bus_write(ADDR_DWELL, 32'd0);
        bus_write(ADDR_CTRL, 32'h1);
        for (int t = 0; t < 11; t++) begin
            if (mask_wr[t][4]) bus_write(ADDR_MASK, 32'(mask_wr[t][3:0]));
            vsync_pulse();
            n_vec++;
            if (color_sel !== exp_c[t] || color_chg !== exp_g[t]) begin
                n_err++;
                $display("FAIL mask_tick%0d: got sel=%0d chg=%b expected sel=%0d chg=%b",
                         t + 1, color_sel, color_chg, exp_c[t], exp_g[t]);
            end
        end
    endtask

    task automatic test_write_with_tick();
        logic [31:0] rd;
        apply_reset();
        bus_write(ADDR_DWELL, 32'd4);
        bus_write(ADDR_CTRL, 32'h1);
        vsync_pulse();
        @(negedge clk);
        vsync          = 1'b1;
        bus.address    = ADDR_DWELL;
        bus.writedata  = 32'd2;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        vsync          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        n_vec++;
        if (color_sel !== 2'd0 || color_chg !== 1'b0) begin
            n_err++;
            $display("FAIL wrtick_no_advance: got sel=%0d chg=%b expected sel=0 chg=0", color_sel, color_chg);
        end
        bus_read(ADDR_STATUS, rd);
        n_vec++;
        if (rd !== 32'h0002_0004) begin
            n_err++;
            $display("FAIL wrtick_status: got %h expected 00020004", rd);
        end
        bus_read(ADDR_DWELL, rd);
        n_vec++;
        if (rd !== 32'd2) begin
            n_err++;
            $display("FAIL wrtick_dwell: got %h expected 00000002", rd);
        end
        vsync_pulse();
        n_vec++;
        if (color_sel !== 2'd0) begin
            n_err++;
            $display("FAIL wrtick_after1: got sel=%0d expected 0", color_sel);
        end
        vsync_pulse();
        n_vec++;
        if (color_sel !== 2'd1 || color_chg !== 1'b1) begin
            n_err++;
            $display("FAIL wrtick_after2: got sel=%0d chg=%b expected sel=1 chg=1", color_sel, color_chg);
        end
    endtask

    task automatic test_run_to_idle();
        logic [31:0] rd;
        bus_write(ADDR_CTRL, 32'hC);
        bus_read(ADDR_STATUS, rd);
        n_vec++;
        if (rd !== 32'h0004_0001) begin
            n_err++;
            $display("FAIL idle_hold_status: got %h expected 00040001", rd);
        end
        bus_read(ADDR_CTRL, rd);
        n_vec++;
        if (rd !== 32'h0000_000C) begin
            n_err++;
            $display("FAIL idle_ctrl_read: got %h expected 0000000c", rd);
        end
        vsync_pulse();
        n_vec++;
        if (color_sel !== 2'd3 || color_chg !== 1'b1) begin
            n_err++;
            $display("FAIL idle_load: got sel=%0d chg=%b expected sel=3 chg=1", color_sel, color_chg);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        apply_reset();
        bus_write(ADDR_DWELL, 32'd1);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) vsync_pulse();
        n_vec++;
        if (color_sel !== 2'd3) begin
            n_err++;
            $display("FAIL midrun_setup: got sel=%0d expected 3", color_sel);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (color_sel !== 2'd0 || color_chg !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset: got sel=%0d chg=%b expected sel=0 chg=0", color_sel, color_chg);
        end
        bus_read(ADDR_STATUS, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL midrun_status: got %h expected 00000000", rd);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (color_sel !== 2'd0 || color_chg !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_release: got sel=%0d chg=%b expected sel=0 chg=0", color_sel, color_chg);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        vsync          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
        test_reset();
        test_manual();
        test_auto_rotate();
        test_dwell_zero_mask();
        test_write_with_tick();
        test_run_to_idle();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
